// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Holds the FSM state encoding, word/lane geometry and fault codes.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // err_o is a single bit today; these codes leave room to widen it.
    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-lane writes and a registered read port.
// Ports: clk_i, en_i (access strobe), we_i, idx_i, be_i, wdata_i, rdata_o.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LANES-1:0]  be_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < LANES; k++) begin
                    if (be_i[k]) begin
                        mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_o <= mem[idx_i];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the MEM-stage load/store port: fixed-latency access, ack, stall.
// Ports: clk_i, rst_i, req_i/we_i/addr_i/wdata_i/be_i in; ready_o, ack_o, rdata_o, err_o, stall_o out.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    parameter  int LATENCY     = 3,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [LANES-1:0]  be_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [LANES-1:0]  be_q;
    logic              rd_ok_q;

    logic              cur_we;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [LANES-1:0]  cur_be;
    logic [1:0]        fcode;
    logic              go_resp;
    logic              arr_en;
    logic [WORD_W-1:0] arr_rdata;

    // With LATENCY=1 the access happens on the acceptance edge itself,
    // so the live inputs stand in for the holding registers.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == S_IDLE) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_be    = be_i;
        end
    end

    always_comb begin
        fcode = FLT_NONE;
        if (cur_addr[1:0] != 2'b00) begin
            fcode = FLT_MISALIGN;
        end else if (cur_addr[WORD_W-1:2] >= 30'(DEPTH_WORDS)) begin
            fcode = FLT_RANGE;
        end
    end

    assign go_resp = !rst_i &&
        ((state_q == S_IDLE && req_i && LATENCY == 1) ||
         (state_q == S_WAIT && cnt_q == '0));

    assign arr_en = go_resp && (fcode == FLT_NONE);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (arr_en),
        .we_i    (cur_we),
        .idx_i   (cur_addr[IDX_W+1:2]),
        .be_i    (cur_be),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rd_ok_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            ack_o   <= go_resp;
            err_o   <= go_resp && (fcode != FLT_NONE);
            rd_ok_q <= go_resp && !cur_we && (fcode == FLT_NONE);
            unique case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (LATENCY == 1) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stores and faults return zero data.
    assign rdata_o = rd_ok_q ? arr_rdata : '0;
    assign ready_o = (state_q == S_IDLE);

    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            S_IDLE:  stall_o = req_i;
            S_WAIT:  stall_o = 1'b1;
            S_RESP:  stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven loads/stores with a
// response scoreboard, plus reset, mid-WAIT reset and LATENCY=1 sequences.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        stall;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [3:0]  be1;
    logic        ready1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        err1;
    logic        stall1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .ready_o (ready),
        .ack_o   (ack),
        .rdata_o (rdata),
        .err_o   (err),
        .stall_o (stall)
    );

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (1)
    ) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req1),
        .we_i    (we1),
        .addr_i  (addr1),
        .wdata_i (wdata1),
        .be_i    (be1),
        .ready_o (ready1),
        .ack_o   (ack1),
        .rdata_o (rdata1),
        .err_o   (err1),
        .stall_o (stall1)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops one expected response.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_err", 32'(err), 32'(e.err));
                check("resp_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic do_req(input logic        a_we,
                          input logic [31:0] a_addr,
                          input logic [31:0] a_wdata,
                          input logic [3:0]  a_be,
                          input logic        e_err,
                          input logic [31:0] e_rdata);
        int cyc;
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        wdata = a_wdata;
        be    = a_be;
        #1;
        check("ready_at_req", 32'(ready), 32'd1);
        check("stall_at_req", 32'(stall), 32'd1);
        e.err   = e_err;
        e.rdata = e_rdata;
        sb.push_back(e);
        cyc = 0;
        while (ack !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
            if (ack !== 1'b1) begin
                check("stall_wait", 32'(stall), 32'd1);
                check("ready_wait", 32'(ready), 32'd0);
            end
        end
        check("latency", 32'(cyc), 32'(LAT));
        check("stall_resp", 32'(stall), 32'd0);
        req = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        be     = '0;
        req1   = 1'b0;
        we1    = 1'b0;
        addr1  = '0;
        wdata1 = '0;
        be1    = '0;

        vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44});
        vecs.push_back('{1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDE22BE44});
        vecs.push_back('{1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h400, 32'h12345678, 4'hF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 32'h4, 32'h01020304, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'h01020304});
        vecs.push_back('{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 32'h80000000, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h20, 32'h0BADCAFE, 4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0BADCAFE});

        // Reset and idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_ack1", 32'(ack1), 32'd0);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].be, vecs[i].err, vecs[i].rdata);
        end

        // Reset while the store sits in WAIT: it must be dropped.
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'hFFFFFFFF;
        be    = 4'hF;
        @(negedge clk);
        #1;
        check("midwait_stall", 32'(stall), 32'd1);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("midwait_noack", 32'(ack), 32'd0);
            @(negedge clk);
            #1;
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0BADCAFE);

        // LATENCY=1 with the request held continuously.
        @(negedge clk);
        req1   = 1'b1;
        we1    = 1'b1;
        addr1  = 32'h8;
        wdata1 = 32'h600DF00D;
        be1    = 4'hF;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("l1_stall", 32'(stall1), 32'(i % 2 == 0));
            check("l1_ack", 32'(ack1), 32'(i % 2 == 1));
            @(negedge clk);
            #1;
        end
        we1 = 1'b0;
        check("l1_load_stall", 32'(stall1), 32'd1);
        @(negedge clk);
        #1;
        check("l1_load_ack", 32'(ack1), 32'd1);
        check("l1_load_rdata", rdata1, 32'h600DF00D);
        check("l1_load_err", 32'(err1), 32'd0);
        req1 = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
